// File: rtl/icap_stream_writer.sv
// icap_stream_writer: pops wide beats from a non-FWFT bitstream FIFO and
// serialises each beat into ICAP_WIDTH-bit ICAPE2 configuration writes,
// with back-to-back beat streaming, an abort sequence and a word counter.
module icap_stream_writer #(
  parameter int FIFO_WIDTH   = 256,
  parameter int ICAP_WIDTH   = 32,
  parameter int MSW_FIRST    = 0,
  parameter int BIT_SWAP     = 1,
  parameter int ABORT_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic [ICAP_WIDTH-1:0] icap_data,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  input  logic                  abort,
  output logic                  abort_done,
  output logic                  busy,
  output logic [31:0]           word_count
);

  localparam int NWORDS = FIFO_WIDTH / ICAP_WIDTH;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int ACNT_W = $clog2(ABORT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [ACNT_W-1:0] ACNT_END = ACNT_W'(ABORT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_SHIFT, S_DONE, S_ABORT
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ACNT_W-1:0]       acnt_q, acnt_d;
  logic [FIFO_WIDTH-1:0]   beat_q, beat_d;
  logic [ICAP_WIDTH-1:0]   data_q, data_d;
  logic                    csib_q, csib_d;
  logic                    rdwrb_q, rdwrb_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [31:0]             wcnt_q, wcnt_d;
  logic                    last_word;

  // Reverse bit order inside every byte when BIT_SWAP is set.
  function automatic logic [ICAP_WIDTH-1:0] bit_swap(input logic [ICAP_WIDTH-1:0] w);
    logic [ICAP_WIDTH-1:0] r;
    r = w;
    if (BIT_SWAP != 0) begin
      for (int b = 0; b < ICAP_WIDTH / 8; b++) begin
        for (int i = 0; i < 8; i++) begin
          r[8*b+i] = w[8*b+7-i];
        end
      end
    end
    return r;
  endfunction

  // Select the word sent at sequence position seq, honouring word order.
  function automatic logic [ICAP_WIDTH-1:0] pick_word(input logic [FIFO_WIDTH-1:0] beat,
                                                      input logic [IDX_W-1:0] seq);
    int w;
    w = (MSW_FIRST != 0) ? (NWORDS - 1 - int'(seq)) : int'(seq);
    return beat[w*ICAP_WIDTH +: ICAP_WIDTH];
  endfunction

  assign last_word = (idx_q == LAST_IDX);

  // Next-state, FIFO pop strobe and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acnt_d     = acnt_q;
    beat_d     = beat_q;
    data_d     = data_q;
    wcnt_d     = wcnt_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (abort) begin
          state_d = S_ABORT;
          acnt_d  = '0;
        end else if (!fifo_empty) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        // The pop is committed even when aborting; that beat is then discarded.
        fifo_rd_en = !fifo_empty;
        acnt_d     = '0;
        state_d    = abort ? S_ABORT : S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_ABORT;
          acnt_d  = '0;
        end else begin
          beat_d  = fifo_data;
          idx_d   = '0;
          data_d  = bit_swap(pick_word(fifo_data, '0));
          wcnt_d  = wcnt_q + 32'd1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_ABORT;
          acnt_d  = '0;
        end else if (!last_word) begin
          idx_d  = idx_q + 1'b1;
          data_d = bit_swap(pick_word(beat_q, idx_q + 1'b1));
          wcnt_d = wcnt_q + 32'd1;
        end else if (!fifo_empty) begin
          // Pop the next beat now so only a single LOAD bubble separates beats.
          fifo_rd_en = 1'b1;
          state_d    = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (acnt_q == ACNT_END) begin
          state_d = S_IDLE;
        end else begin
          acnt_d = acnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reset) begin
      fifo_rd_en = 1'b0;
    end

    // Registered outputs follow the state being entered.
    csib_d  = 1'b1;
    rdwrb_d = 1'b1;
    done_d  = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      S_IDLE:  busy_d = 1'b0;
      S_READ,
      S_LOAD,
      S_DONE:  rdwrb_d = 1'b0;
      S_SHIFT: begin
        csib_d  = 1'b0;
        rdwrb_d = 1'b0;
      end
      S_ABORT: begin
        if (acnt_d == ACNT_END) begin
          done_d = 1'b1;
        end else begin
          csib_d = 1'b0;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acnt_q  <= '0;
      data_q  <= '0;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acnt_q  <= acnt_d;
      data_q  <= data_d;
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Beat holding register; pure data, never needs a reset value.
  always_ff @(posedge clock) begin
    beat_q <= beat_d;
  end

  assign icap_data  = data_q;
  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign abort_done = done_q;
  assign busy       = busy_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_icap_stream_writer.sv
// Scoreboard bench for icap_stream_writer: two instances (default parameters,
// and a 64-bit MSW-first pass-through variant) each fed by a FIFO model.
module tb_icap_stream_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         abort_a = 1'b0, abort_b = 1'b0;
  logic         empty_a = 1'b1, empty_b = 1'b1;
  logic         rd_a, rd_b;
  logic [255:0] fdata_a = '0;
  logic [63:0]  fdata_b = '0;
  logic [31:0]  data_a, data_b, wc_a, wc_b;
  logic         csib_a, rdwrb_a, done_a, busy_a;
  logic         csib_b, rdwrb_b, done_b, busy_b;

  logic [255:0] qa[$];
  logic [63:0]  qb[$];
  logic [31:0]  exp_a[$];
  logic [31:0]  exp_b[$];
  logic         pend_a = 1'b0, pend_b = 1'b0;
  int           rdcnt_a = 0, rdcnt_b = 0;

  int n_cmp = 0;
  int n_err = 0;

  icap_stream_writer dut_a (
    .clock(clk), .reset(reset), .fifo_empty(empty_a), .fifo_rd_en(rd_a),
    .fifo_data(fdata_a), .icap_data(data_a), .icap_csib(csib_a),
    .icap_rdwrb(rdwrb_a), .abort(abort_a), .abort_done(done_a),
    .busy(busy_a), .word_count(wc_a)
  );

  icap_stream_writer #(
    .FIFO_WIDTH(64), .ICAP_WIDTH(32), .MSW_FIRST(1), .BIT_SWAP(0), .ABORT_CYCLES(4)
  ) dut_b (
    .clock(clk), .reset(reset), .fifo_empty(empty_b), .fifo_rd_en(rd_b),
    .fifo_data(fdata_b), .icap_data(data_b), .icap_csib(csib_b),
    .icap_rdwrb(rdwrb_b), .abort(abort_b), .abort_done(done_b),
    .busy(busy_b), .word_count(wc_b)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // FIFO models: a pop strobe seen at a rising edge delivers data one cycle later.
  always @(posedge clk) begin
    pend_a <= rd_a;
    pend_b <= rd_b;
    if (rd_a) rdcnt_a <= rdcnt_a + 1;
    if (rd_b) rdcnt_b <= rdcnt_b + 1;
  end

  always @(negedge clk) begin
    if (pend_a && qa.size() > 0) fdata_a <= qa.pop_front();
    empty_a <= (qa.size() == 0);
    if (pend_b && qb.size() > 0) fdata_b <= qb.pop_front();
    empty_b <= (qb.size() == 0);
  end

  // Monitors: every ICAP write cycle is matched against the expected queue.
  always @(negedge clk) begin : mon_a
    logic [31:0] e;
    if (!csib_a && !rdwrb_a) begin
      if (exp_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_word: got %0h required no write", data_a);
      end else begin
        e = exp_a.pop_front();
        check("a_word", 64'(data_a), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [31:0] e;
    if (!csib_b && !rdwrb_b) begin
      if (exp_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_word: got %0h required no write", data_b);
      end else begin
        e = exp_b.pop_front();
        check("b_word", 64'(data_b), 64'(e));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_exp_a(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_a.push_back(w);
  endtask

  task automatic push_a(input logic [255:0] b);
    @(posedge clk);
    #1;
    qa.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_first_a(output int lat);
    lat = 0;
    while (csib_a && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_idle_a(input string nm);
    int n;
    n = 0;
    while ((busy_a || exp_a.size() != 0 || qa.size() != 0) && n < 400) begin
      step();
      n++;
    end
    check(nm, 64'(n < 400), 64'd1);
  endtask

  logic [39:0] tc, tr, ec, er;
  int          lat, n, rd0, wc0;

  initial begin
    // Reset state, with a beat already waiting in the FIFO.
    push_exp_a(32'h20C04080, 1); push_exp_a(32'h10E060A0, 1);
    push_exp_a(32'h20C04080, 1); push_exp_a(32'h10E060A0, 1);
    push_exp_a(32'h20C04080, 1); push_exp_a(32'h10E060A0, 1);
    push_exp_a(32'h20C04080, 1); push_exp_a(32'h10E060A0, 1);
    qa.push_back({4{64'h0807060504030201}});
    repeat (3) step();
    check("reset_ctrl", 64'({rd_a, csib_a, rdwrb_a, done_a, busy_a}), 64'b01100);
    check("reset_data", 64'(data_a), 64'd0);
    check("reset_wc", 64'(wc_a), 64'd0);
    reset = 1'b0;

    // Single beat with default parameters.
    wait_first_a(lat);
    check("a_latency", 64'(lat), 64'd3);
    n = 1;
    while (n < 20) begin
      step();
      if (csib_a) break;
      n++;
    end
    check("a_burst_len", 64'(n), 64'd8);
    check("a_done_state", 64'({csib_a, rdwrb_a, busy_a}), 64'b101);
    step();
    check("a_idle_after", 64'({rdwrb_a, busy_a}), 64'b10);
    check("a_wc_single", 64'(wc_a), 64'd8);

    // Four beats queued back-to-back.
    push_exp_a(32'h80808080, 8);
    push_exp_a(32'h40404040, 8);
    push_exp_a(32'hF0F0F0F0, 8);
    push_exp_a(32'h8844CC22, 8);
    rd0 = rdcnt_a;
    @(posedge clk);
    #1;
    qa.push_back({8{32'h01010101}});
    qa.push_back({8{32'h02020202}});
    qa.push_back({8{32'h0F0F0F0F}});
    qa.push_back({8{32'h11223344}});
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      step();
      tc[i] = csib_a;
      tr[i] = rdwrb_a;
      if (i < 2 || i > 36) ec[i] = 1'b1;
      else ec[i] = (((i - 2) % 9) == 8);
      er[i] = (i >= 38);
    end
    check("a_stream_csib", 64'(tc), 64'(ec));
    check("a_stream_rdwrb", 64'(tr), 64'(er));
    check("a_stream_pops", 64'(rdcnt_a - rd0), 64'd4);
    check("a_wc_stream", 64'(wc_a), 64'd40);

    // MSW-first, no bit swap, 64-bit beat.
    exp_b.push_back(32'hAAAAAAAA);
    exp_b.push_back(32'h55555555);
    @(posedge clk);
    #1;
    qb.push_back(64'hAAAAAAAA_55555555);
    n = 0;
    @(negedge clk);
    while ((busy_b || exp_b.size() != 0 || qb.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check("b_idle", 64'(n < 100), 64'd1);
    check("b_wc", 64'(wc_b), 64'd2);

    // Abort during the third SHIFT cycle.
    push_exp_a(32'h80808080, 3);
    rd0 = rdcnt_a;
    wc0 = wc_a;
    push_a({8{32'h01010101}});
    wait_first_a(lat);
    step();
    step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("abort_wc", 64'(wc_a - wc0), 64'd3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check("abort_seq", 64'({csib_a, rdwrb_a, done_a}), 64'b010);
    end
    step();
    check("abort_done", 64'({csib_a, rdwrb_a, done_a, busy_a}), 64'b1111);
    step();
    check("abort_idle", 64'({csib_a, rdwrb_a, done_a, busy_a}), 64'b1100);
    check("abort_pops", 64'(rdcnt_a - rd0), 64'd1);

    // Abort on the last word with another beat waiting.
    push_exp_a(32'hF0F0F0F0, 8);
    rd0 = rdcnt_a;
    @(posedge clk);
    #1;
    qa.push_back({8{32'h0F0F0F0F}});
    qa.push_back({8{32'h11223344}});
    @(negedge clk);
    wait_first_a(lat);
    repeat (7) step();
    abort_a = 1'b1;
    #1;
    check("abort_last_rden", 64'(rd_a), 64'd0);
    step();
    abort_a = 1'b0;
    check("abort_last_seq", 64'({csib_a, rdwrb_a}), 64'b01);
    n = 0;
    while (!done_a && n < 20) begin
      step();
      n++;
    end
    check("abort_last_done", 64'(done_a), 64'd1);
    check("abort_last_level", 64'(qa.size()), 64'd1);
    check("abort_last_pops", 64'(rdcnt_a - rd0), 64'd1);
    push_exp_a(32'h8844CC22, 8);
    wait_idle_a("abort_resume_idle");
    check("abort_resume_pops", 64'(rdcnt_a - rd0), 64'd2);

    // Reset while the fifth word is on the bus.
    push_exp_a(32'h40404040, 5);
    rd0 = rdcnt_a;
    push_a({8{32'h02020202}});
    wait_first_a(lat);
    repeat (4) step();
    reset = 1'b1;
    step();
    check("midreset_ctrl", 64'({csib_a, rdwrb_a, done_a, busy_a}), 64'b1100);
    check("midreset_wc", 64'(wc_a), 64'd0);
    reset = 1'b0;
    check("midreset_pops", 64'(rdcnt_a - rd0), 64'd1);
    push_exp_a(32'hF0F0F0F0, 8);
    push_a({8{32'h0F0F0F0F}});
    wait_idle_a("after_reset_idle");
    check("after_reset_wc", 64'(wc_a), 64'd8);

    step();
    check("a_exp_left", 64'(exp_a.size()), 64'd0);
    check("b_exp_left", 64'(exp_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
